// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divider controller.
// One quotient bit retires per clock. The partial remainder is kept in
// WIDTH+1 bits, so divisors of 2^(WIDTH-1) or more never wrap in the trial
// subtract.
// Optional build macro DIV_SEQ_SIGNED_EN: signed two's-complement operands.
// The divider works on magnitudes and the signs are applied in FIXUP.
// Timing is the same with or without the macro.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] M,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] Quo,
  output logic [WIDTH-1:0] R
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_ITER, S_FIXUP, S_DONE
  } state_t;

  state_t             r_state;
  logic [2*WIDTH:0]   r_a;      // {partial remainder (W+1), quotient/dividend (W)}
  logic [WIDTH-1:0]   r_m;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_r;

  logic [2*WIDTH:0]   w_shift;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // One restoring step: shift, then trial-subtract the divisor from the upper half
  assign w_shift = r_a << 1;
  assign w_trial = w_shift[2*WIDTH:WIDTH] - {1'b0, r_m};

`ifdef DIV_SEQ_SIGNED_EN
  logic             r_sq;
  logic             r_sm;
  logic [WIDTH-1:0] w_q_abs;
  logic [WIDTH-1:0] w_m_abs;

  // Magnitudes for PREP. The most-negative value maps onto itself, which is
  // also its correct unsigned magnitude.
  assign w_q_abs   = r_a[WIDTH-1] ? -r_a[WIDTH-1:0] : r_a[WIDTH-1:0];
  assign w_m_abs   = r_m[WIDTH-1] ? -r_m : r_m;
  // Truncating division: quotient sign = sq^sm, remainder takes the dividend sign
  assign w_quo_fix = (r_sq ^ r_sm) ? -r_a[WIDTH-1:0] : r_a[WIDTH-1:0];
  assign w_rem_fix = r_sq ? -r_a[2*WIDTH-1:WIDTH] : r_a[2*WIDTH-1:WIDTH];

  // Sign flags are recorded in PREP and consumed in FIXUP
  always_ff @(posedge clock) begin
    if (clear) begin
      r_sq <= 1'b0;
      r_sm <= 1'b0;
    end else if (r_state == S_PREP) begin
      r_sq <= r_a[WIDTH-1];
      r_sm <= r_m[WIDTH-1];
    end
  end
`else
  assign w_quo_fix = r_a[WIDTH-1:0];
  assign w_rem_fix = r_a[2*WIDTH-1:WIDTH];
`endif

  // Sequencer FSM. All datapath registers and outputs are updated here.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_m        <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_quo      <= '0;
      r_r        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= {{(WIDTH+1){1'b0}}, Q};
            r_m     <= M;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          if (r_m == '0) begin
            // Divide by zero: R gets the dividend exactly as it was given
            r_quo      <= '1;
            r_r        <= r_a[WIDTH-1:0];
            r_div_zero <= 1'b1;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
`ifdef DIV_SEQ_SIGNED_EN
            r_a <= {{(WIDTH+1){1'b0}}, w_q_abs};
            r_m <= w_m_abs;
`endif
            r_cnt      <= CW'(WIDTH - 1);
            r_div_zero <= 1'b0;
            r_state    <= S_ITER;
          end
        end
        S_ITER: begin
          if (w_trial[WIDTH])
            r_a <= w_shift;
          else
            r_a <= {w_trial, w_shift[WIDTH-1:1], 1'b1};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0)
            r_state <= S_FIXUP;
        end
        S_FIXUP: begin
          r_quo   <= w_quo_fix;
          r_r     <= w_rem_fix;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign Quo      = r_quo;
  assign R        = r_r;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: self-checking bench for div_sequencer with a reference
// model based on arithmetic division. Define DIV_SEQ_SIGNED_EN to check the
// signed build.
module tb_div_sequencer;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic [W-1:0] Q;
  logic [W-1:0] M;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] Quo;
  logic [W-1:0] R;

  int checks   = 0;
  int failures = 0;

  div_sequencer #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start), .Q(Q), .M(M),
    .busy(busy), .done(done), .div_zero(div_zero), .Quo(Quo), .R(R)
  );

  always #5 clock = ~clock;

  // Reference: the result of the division, taken straight from the arithmetic
  function automatic void model(input logic [W-1:0] q, input logic [W-1:0] m,
                                output logic [W-1:0] eq, output logic [W-1:0] er,
                                output logic ez);
    longint sq, sm;
    sq = longint'($signed(q));
    sm = longint'($signed(m));
    if (m == '0) begin
      eq = '1; er = q; ez = 1'b1;
    end else begin
      ez = 1'b0;
`ifdef DIV_SEQ_SIGNED_EN
      eq = W'(sq / sm);
      er = W'(sq % sm);
`else
      if (sq == sm) ;  // the signed values are not needed in the unsigned build
      eq = q / m;
      er = q % m;
`endif
    end
  endfunction

  // Issue one divide with a single-cycle start. Scramble Q/M after acceptance.
  // lat is the done cycle, counted from the cycle after the acceptance edge (0 = timeout).
  // busy_ok checks that busy stays high until done and drops in the following cycle.
  task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] m,
                        output logic [W-1:0] oq, output logic [W-1:0] orr,
                        output logic oz, output int lat, output bit busy_ok);
    @(negedge clock);
    Q = q; M = m; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; Q = $urandom; M = $urandom;
    lat = 0; busy_ok = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin lat = c; break; end
      @(posedge clock); #1;
    end
    oq = Quo; orr = R; oz = div_zero;
    @(posedge clock); #1;
    if (busy !== 1'b0 || done !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b0; Q = '0; M = '0;
    repeat (3) @(posedge clock);
    #1 clear = 1'b0;
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || Quo !== '0 || R !== '0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b dz=%b Quo=%h R=%h, want all zero",
               busy, done, div_zero, Quo, R);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] q, r; logic z; int lat; bit bok;
    run_op(32'd100, 32'd7, q, r, z, lat, bok);
    checks++;
    if (q !== 32'd14 || r !== 32'd2 || z !== 1'b0) begin
      failures++;
      $display("FAIL basic_100_7: Quo=%0d R=%0d dz=%b, want 14 2 0", q, r, z);
    end
    checks++;
    if (lat !== W + 3) begin
      failures++; $display("FAIL basic_latency: got %0d, want %0d", lat, W + 3);
    end
    checks++;
    if (!bok) begin failures++; $display("FAIL basic_busy: busy window wrong, want 1..%0d", W + 3); end
  endtask

  task automatic test_spec_vectors();
    logic [W-1:0] q, r; logic z; int lat; bit bok;
    run_op(32'hFFFF_FFFF, 32'h8000_0000, q, r, z, lat, bok);
    checks++;
`ifdef DIV_SEQ_SIGNED_EN
    if (q !== 32'h0 || r !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL large_div: Quo=%h R=%h, want 0 ffffffff", q, r);
    end
`else
    if (q !== 32'h1 || r !== 32'h7FFF_FFFF) begin
      failures++; $display("FAIL large_div: Quo=%h R=%h, want 1 7fffffff", q, r);
    end
`endif
    run_op(32'hFFFF_FFF9, 32'd2, q, r, z, lat, bok);
    checks++;
`ifdef DIV_SEQ_SIGNED_EN
    if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL neg7_div2: Quo=%h R=%h, want fffffffd ffffffff", q, r);
    end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, q, r, z, lat, bok);
    checks++;
    if (q !== 32'h8000_0000 || r !== 32'h0 || z !== 1'b0) begin
      failures++; $display("FAIL minneg_div_m1: Quo=%h R=%h dz=%b, want 80000000 0 0", q, r, z);
    end
`else
    if (q !== 32'h7FFF_FFFC || r !== 32'h1) begin
      failures++; $display("FAIL neg7_div2: Quo=%h R=%h, want 7ffffffc 1", q, r);
    end
`endif
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r; logic z; int lat; bit bok;
    run_op(32'h1234, 32'h0, q, r, z, lat, bok);
    checks++;
    if (q !== 32'hFFFF_FFFF || r !== 32'h1234 || z !== 1'b1) begin
      failures++; $display("FAIL divzero_result: Quo=%h R=%h dz=%b, want ffffffff 1234 1", q, r, z);
    end
    checks++;
    if (lat !== 2 || !bok) begin
      failures++; $display("FAIL divzero_latency: lat=%0d busy_ok=%b, want 2 1", lat, bok);
    end
    checks++;
    if (div_zero !== 1'b1 || Quo !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL divzero_hold: dz=%b Quo=%h, want 1 ffffffff", div_zero, Quo);
    end
    run_op(32'd9, 32'd3, q, r, z, lat, bok);
    checks++;
    if (q !== 32'd3 || r !== 32'd0 || z !== 1'b0) begin
      failures++; $display("FAIL after_divzero: Quo=%0d R=%0d dz=%b, want 3 0 0", q, r, z);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] q, r; logic z; int lat; bit bok; int ndone;
    run_op(32'h55, 32'h0, q, r, z, lat, bok);   // leaves nonzero held outputs
    @(negedge clock);
    Q = 32'd1000; M = 32'd3; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;          // cycle 1 = PREP
    repeat (10) @(posedge clock);               // cycle 11 = ITER cycle 10
    #1 clear = 1'b1;
    @(posedge clock); #1 clear = 1'b0;
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || Quo !== '0 || R !== '0) begin
      failures++;
      $display("FAIL reset_mid_op: busy=%b done=%b dz=%b Quo=%h R=%h, want all zero",
               busy, done, div_zero, Quo, R);
    end
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin failures++; $display("FAIL reset_no_done: %0d active cycles, want 0", ndone); end
    run_op(32'd1000, 32'd3, q, r, z, lat, bok);
    checks++;
    if (q !== 32'd333 || r !== 32'd1 || lat !== W + 3) begin
      failures++; $display("FAIL after_reset: Quo=%0d R=%0d lat=%0d, want 333 1 %0d", q, r, lat, W + 3);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q0, m0, q1, m1, eq, er; logic ez; int lat, ndone;
    q0 = $urandom; m0 = $urandom_range(1, 1000);
    q1 = $urandom; m1 = $urandom_range(1, 70000);
    @(negedge clock);
    Q = q0; M = m0; start = 1'b1;
    @(posedge clock); #1;
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      if (done === 1'b1) begin lat = c; break; end
      Q = $urandom; M = $urandom;
      @(posedge clock); #1;
    end
    model(q0, m0, eq, er, ez);
    checks++;
    if (lat !== W + 3 || Quo !== eq || R !== er) begin
      failures++; $display("FAIL hs_first: lat=%0d Quo=%h R=%h, want %0d %h %h", lat, Quo, R, W + 3, eq, er);
    end
    Q = q1; M = m1;                             // start still high during DONE
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL hs_idle_gap: busy=%b done=%b, want 0 0", busy, done);
    end
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL hs_second_accept: busy=%b, want 1", busy); end
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      if (done === 1'b1) begin lat = c; break; end
      Q = $urandom; M = $urandom;
      @(posedge clock); #1;
    end
    start = 1'b0;
    model(q1, m1, eq, er, ez);
    checks++;
    if (lat !== W + 3 || Quo !== eq || R !== er) begin
      failures++; $display("FAIL hs_second: lat=%0d Quo=%h R=%h, want %0d %h %h", lat, Quo, R, W + 3, eq, er);
    end
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin failures++; $display("FAIL hs_extra_done: %0d extra pulses, want 0", ndone); end
  endtask

  task automatic test_random();
    logic [W-1:0] q, m, oq, orr, eq, er; logic oz, ez; int lat, elat; bit bok;
    for (int i = 0; i < 40; i++) begin
      q = $urandom;
      case ($urandom_range(0, 3))
        0: m = $urandom;
        1: m = $urandom_range(1, 255);
        2: m = $urandom | 32'h8000_0000;
        default: m = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
      endcase
      if (i == 3) q = 32'h8000_0000;
      run_op(q, m, oq, orr, oz, lat, bok);
      model(q, m, eq, er, ez);
      elat = (m == '0) ? 2 : W + 3;
      checks++;
      if (oq !== eq || orr !== er || oz !== ez || lat !== elat || !bok) begin
        failures++;
        $display("FAIL random[%0d] q=%h m=%h: Quo=%h R=%h dz=%b lat=%0d busy_ok=%b, want %h %h %b %0d 1",
                 i, q, m, oq, orr, oz, lat, bok, eq, er, ez, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_spec_vectors();
    test_div_zero();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
